// File: rtl/vend_arbiter_pkg.sv
// Shared definitions for the two-requester vending arbiter: FSM encodings and
// the credit-update rule used by both per-requester counters.
package vend_arbiter_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT    = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // A charge only happens for a requester whose credit already covers the
    // price, so charge-plus-coin can never overflow; plain coins saturate at 7.
    function automatic logic [2:0] creditNext(
        input logic [2:0] cur,
        input logic       charge,
        input logic [2:0] price,
        input logic       coinIn
    );
        logic [2:0] base;
        base = charge ? (cur - price) : cur;
        if (coinIn && (base != 3'd7)) begin
            return base + 3'd1;
        end
        return base;
    endfunction

endpackage

// File: rtl/vend_arbiter_tff.sv
// Toggle flip-flop cell with asynchronous active-high reset to a fixed value.
module vend_arbiter_tff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/vend_arbiter.sv
// Two-requester vending arbiter: per-requester coin credit, shared stock and a
// Moore FSM that grants one vend at a time with alternating priority on ties.
module vend_arbiter
    import vend_arbiter_pkg::*;
#(
    parameter int unsigned PRICE      = 3,
    parameter int unsigned DISP_CYC   = 4,
    parameter int unsigned STOCK_INIT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic [1:0] req,
    input  logic       refill,
    output logic [1:0] grant,
    output logic       dispense,
    output logic [2:0] credit0,
    output logic [2:0] credit1,
    output logic       empty,
    output logic       busy
);

    localparam logic [2:0] PRICE3    = 3'(PRICE);
    localparam logic [2:0] STOCK3    = 3'(STOCK_INIT);
    localparam logic [3:0] DISP_LAST = 4'(DISP_CYC - 1);

    logic [1:0] state;
    logic [1:0] nextState;
    logic       winner;
    logic       nextWinner;
    logic       lastServed;
    logic [1:0] eligible;
    logic       startVend;
    logic       commit;
    logic [2:0] stock;
    logic [3:0] dispCnt;

    assign eligible[0] = req[0] && (credit0 >= PRICE3);
    assign eligible[1] = req[1] && (credit1 >= PRICE3);
    assign startVend   = (state == ST_IDLE) && (|eligible) && (stock != 3'd0);
    assign commit      = (state == ST_GRANT);

    // On a tie the requester that was not served most recently wins.
    always_comb begin
        nextWinner = winner;
        if (startVend) begin
            nextWinner = (eligible == 2'b11) ? ~lastServed : eligible[1];
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:     if (startVend) nextState = ST_GRANT;
            ST_GRANT:    nextState = ST_DISPENSE;
            ST_DISPENSE: if (dispCnt == DISP_LAST) nextState = ST_DONE;
            ST_DONE:     nextState = ST_IDLE;
            default:     nextState = ST_IDLE;
        endcase
    end

    // State, winner and last-served pointer are toggle cells: each toggles
    // exactly when its next value differs from the current one.
    for (genvar b = 0; b < 2; b++) begin : g_state
        vend_arbiter_tff #(.RESET_VAL(ST_IDLE[b])) u_state_ff (
            .clk   (clk),
            .reset (reset),
            .t     (state[b] ^ nextState[b]),
            .q     (state[b])
        );
    end

    vend_arbiter_tff #(.RESET_VAL(1'b0)) u_winner_ff (
        .clk   (clk),
        .reset (reset),
        .t     (winner ^ nextWinner),
        .q     (winner)
    );

    vend_arbiter_tff #(.RESET_VAL(1'b1)) u_last_ff (
        .clk   (clk),
        .reset (reset),
        .t     ((state == ST_DONE) && (winner != lastServed)),
        .q     (lastServed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit0 <= 3'd0;
            credit1 <= 3'd0;
        end else begin
            credit0 <= creditNext(credit0, commit && !winner, PRICE3, coin[0]);
            credit1 <= creditNext(credit1, commit &&  winner, PRICE3, coin[1]);
        end
    end

    // Refill is only honoured while idle, so it can never race a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stock <= STOCK3;
        end else if ((state == ST_IDLE) && refill) begin
            stock <= STOCK3;
        end else if (commit) begin
            stock <= stock - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dispCnt <= 4'd0;
        end else if (state == ST_DISPENSE) begin
            dispCnt <= dispCnt + 4'd1;
        end else begin
            dispCnt <= 4'd0;
        end
    end

    assign grant    = (state == ST_GRANT) ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign dispense = (state == ST_DISPENSE);
    assign busy     = (state != ST_IDLE);
    assign empty    = (stock == 3'd0);

endmodule

// File: tb/tb_vend_arbiter.sv
// Self-checking bench for vend_arbiter: directed scenarios plus randomized
// traffic against a vend-timeline model kept in the bench.
module tb_vend_arbiter;

    localparam int PRICE      = 3;
    localparam int DISP_CYC   = 4;
    localparam int STOCK_INIT = 7;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] coin   = 2'b00;
    logic [1:0] req    = 2'b00;
    logic       refill = 1'b0;
    logic [1:0] grant;
    logic       dispense;
    logic [2:0] credit0;
    logic [2:0] credit1;
    logic       empty;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Model: mPos is the cycle index within a vend (-1 idle, 0 grant,
    // 1..DISP_CYC dispensing, DISP_CYC+1 done).
    int mCredit[2];
    int mStock;
    int mLast;
    int mWin;
    int mPos;

    vend_arbiter #(
        .PRICE      (PRICE),
        .DISP_CYC   (DISP_CYC),
        .STOCK_INIT (STOCK_INIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .coin     (coin),
        .req      (req),
        .refill   (refill),
        .grant    (grant),
        .dispense (dispense),
        .credit0  (credit0),
        .credit1  (credit1),
        .empty    (empty),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mCredit[0] = 0;
        mCredit[1] = 0;
        mStock     = STOCK_INIT;
        mLast      = 1;
        mWin       = 0;
        mPos       = -1;
    endfunction

    function automatic void modelStep(input logic [1:0] c, input logic [1:0] r, input logic f);
        int  startWin;
        bit  e0;
        bit  e1;
        startWin = -1;
        e0 = r[0] && (mCredit[0] >= PRICE);
        e1 = r[1] && (mCredit[1] >= PRICE);
        if (mPos < 0 && mStock > 0) begin
            if (e0 && e1)  startWin = 1 - mLast;
            else if (e0)   startWin = 0;
            else if (e1)   startWin = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (mPos == 0 && mWin == i) mCredit[i] = mCredit[i] - PRICE + int'(c[i]);
            else if (c[i] && mCredit[i] < 7) mCredit[i] = mCredit[i] + 1;
        end
        if (mPos == 0) mStock = mStock - 1;
        if (mPos < 0 && f) mStock = STOCK_INIT;
        if (mPos < 0) begin
            if (startWin >= 0) begin
                mWin = startWin;
                mPos = 0;
            end
        end else if (mPos == DISP_CYC + 1) begin
            mLast = mWin;
            mPos  = -1;
        end else begin
            mPos = mPos + 1;
        end
    endfunction

    task automatic applyStimulus(input logic [1:0] c, input logic [1:0] r, input logic f);
        coin   = c;
        req    = r;
        refill = f;
        @(posedge clk);
        modelStep(c, r, f);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        coin   = 2'b00;
        req    = 2'b00;
        refill = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checks++; if (grant !== 2'b00)  begin failures++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (dispense !== 1'b0) begin failures++; $display("[TB] FAIL reset_dispense: got %b expected 0", dispense); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (credit0 !== 3'd0 || credit1 !== 3'd0) begin failures++; $display("[TB] FAIL reset_credit: got %0d/%0d expected 0/0", credit0, credit1); end
        checks++; if (empty !== 1'b0)   begin failures++; $display("[TB] FAIL reset_empty: got %b expected 0", empty); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_single_vend();
        doReset();
        repeat (3) applyStimulus(2'b01, 2'b00, 1'b0);
        checks++; if (credit0 !== 3'd3) begin failures++; $display("[TB] FAIL single_credit_in: got %0d expected 3", credit0); end
        applyStimulus(2'b00, 2'b01, 1'b0);
        checks++; if (grant !== 2'b01 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_grant: got %b busy %b expected 01 busy 1", grant, busy); end
        // req drops right away; the vend must still run to completion
        for (int k = 0; k < DISP_CYC; k++) begin
            applyStimulus(2'b00, 2'b00, 1'b0);
            checks++; if (dispense !== 1'b1 || grant !== 2'b00) begin failures++; $display("[TB] FAIL single_dispense[%0d]: got disp %b grant %b expected 1 00", k, dispense, grant); end
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        checks++; if (busy !== 1'b1 || dispense !== 1'b0) begin failures++; $display("[TB] FAIL single_done: got busy %b disp %b expected 1 0", busy, dispense); end
        applyStimulus(2'b00, 2'b00, 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle: got busy %b expected 0", busy); end
        checks++; if (credit0 !== 3'd0) begin failures++; $display("[TB] FAIL single_credit_out: got %0d expected 0", credit0); end
        checks++; if (dut.stock !== 3'd6) begin failures++; $display("[TB] FAIL single_stock: got %0d expected 6", dut.stock); end
    endtask

    task automatic test_back_to_back();
        int         cyc[$];
        logic [1:0] val[$];
        doReset();
        repeat (3) applyStimulus(2'b11, 2'b00, 1'b0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(2'b00, 2'b11, 1'b0);
            if (grant !== 2'b00) begin
                cyc.push_back(k);
                val.push_back(grant);
            end
        end
        checks++;
        if (cyc.size() != 2) begin
            failures++; $display("[TB] FAIL b2b_count: got %0d grants expected 2", cyc.size());
        end else begin
            checks++; if (val[0] !== 2'b01) begin failures++; $display("[TB] FAIL b2b_first: got %b expected 01", val[0]); end
            checks++; if (val[1] !== 2'b10) begin failures++; $display("[TB] FAIL b2b_second: got %b expected 10", val[1]); end
            checks++; if (cyc[1] - cyc[0] != DISP_CYC + 3) begin failures++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", cyc[1] - cyc[0], DISP_CYC + 3); end
        end
        checks++; if (credit0 !== 3'd0 || credit1 !== 3'd0) begin failures++; $display("[TB] FAIL b2b_credit: got %0d/%0d expected 0/0", credit0, credit1); end
    endtask

    task automatic test_saturation();
        doReset();
        repeat (8) applyStimulus(2'b10, 2'b00, 1'b0);
        checks++; if (credit1 !== 3'd7) begin failures++; $display("[TB] FAIL sat_credit1: got %0d expected 7", credit1); end
        checks++; if (credit0 !== 3'd0) begin failures++; $display("[TB] FAIL sat_credit0: got %0d expected 0", credit0); end
    endtask

    task automatic test_empty_refill();
        int seen;
        doReset();
        for (int v = 0; v < STOCK_INIT; v++) begin
            repeat (3) applyStimulus(2'b01, 2'b00, 1'b0);
            applyStimulus(2'b00, 2'b01, 1'b0);
            repeat (DISP_CYC + 2) applyStimulus(2'b00, 2'b00, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
        repeat (3) applyStimulus(2'b01, 2'b00, 1'b0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b00, 2'b01, 1'b0);
            if (grant !== 2'b00 || busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("[TB] FAIL empty_nogrant: got %0d active cycles expected 0", seen); end
        applyStimulus(2'b00, 2'b01, 1'b1);
        checks++; if (empty !== 1'b0 || dut.stock !== 3'd7) begin failures++; $display("[TB] FAIL refill_stock: got empty %b stock %0d expected 0 7", empty, dut.stock); end
        applyStimulus(2'b00, 2'b01, 1'b0);
        checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL refill_vend: got %b expected 01", grant); end
        repeat (DISP_CYC + 2) applyStimulus(2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_coin_at_commit_and_reset();
        doReset();
        repeat (3) applyStimulus(2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b01, 1'b0);
        applyStimulus(2'b11, 2'b00, 1'b0);
        checks++; if (credit0 !== 3'd1) begin failures++; $display("[TB] FAIL commit_coin_winner: got %0d expected 1", credit0); end
        checks++; if (credit1 !== 3'd1) begin failures++; $display("[TB] FAIL commit_coin_other: got %0d expected 1", credit1); end
        checks++; if (dispense !== 1'b1) begin failures++; $display("[TB] FAIL pre_abort_dispense: got %b expected 1", dispense); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dispense !== 1'b0 || busy !== 1'b0 || grant !== 2'b00) begin failures++; $display("[TB] FAIL abort_outputs: got disp %b busy %b grant %b expected 0 0 00", dispense, busy, grant); end
        checks++; if (credit0 !== 3'd0 || credit1 !== 3'd0 || empty !== 1'b0) begin failures++; $display("[TB] FAIL abort_state: got %0d/%0d empty %b expected 0/0 0", credit0, credit1, empty); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_random();
        logic [1:0] eg;
        logic [1:0] c;
        logic [1:0] r;
        logic       f;
        doReset();
        for (int k = 0; k < 400; k++) begin
            c = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 15) == 0);
            applyStimulus(c, r, f);
            eg = (mPos == 0) ? ((mWin == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (grant !== eg) begin failures++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", k, grant, eg); end
            checks++; if (dispense !== (mPos >= 1 && mPos <= DISP_CYC)) begin failures++; $display("[TB] FAIL rand_dispense[%0d]: got %b expected %b", k, dispense, (mPos >= 1 && mPos <= DISP_CYC)); end
            checks++; if (busy !== (mPos >= 0)) begin failures++; $display("[TB] FAIL rand_busy[%0d]: got %b expected %b", k, busy, (mPos >= 0)); end
            checks++; if (empty !== (mStock == 0)) begin failures++; $display("[TB] FAIL rand_empty[%0d]: got %b expected %b", k, empty, (mStock == 0)); end
            checks++; if (credit0 !== 3'(mCredit[0])) begin failures++; $display("[TB] FAIL rand_credit0[%0d]: got %0d expected %0d", k, credit0, mCredit[0]); end
            checks++; if (credit1 !== 3'(mCredit[1])) begin failures++; $display("[TB] FAIL rand_credit1[%0d]: got %0d expected %0d", k, credit1, mCredit[1]); end
        end
    endtask

    initial begin
        modelReset();
        $display("[TB] vend_arbiter bench start");
        test_reset();
        test_single_vend();
        test_back_to_back();
        test_saturation();
        test_empty_refill();
        test_coin_at_commit_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
